quad_step_decoder: RTL

//  Quadrature front end for the 4-bit up/down counter. Takes raw asynchronous encoder phases A/B,

---
 rtl/quad_pkg.sv | 51 +++++
 rtl/quad_sync_filter.sv | 54 +++++
 rtl/quad_step_decoder.sv | 87 ++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature step decoder: FSM states, direction levels,
// Gray-code phase constants and the old->new transition classifier.
package quad_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } quad_state_e;

   typedef enum logic [1:0] {
      TR_NONE = 2'd0,
      TR_UP   = 2'd1,
      TR_DN   = 2'd2,
      TR_ILL  = 2'd3
   } quad_tr_e;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   // Phase pair is packed as {A, B}
   localparam logic [1:0] AB_00 = 2'b00;
   localparam logic [1:0] AB_10 = 2'b10;
   localparam logic [1:0] AB_11 = 2'b11;
   localparam logic [1:0] AB_01 = 2'b01;

   // Successor in the A-leads-B (up) rotation 00->10->11->01->00
   function automatic logic [1:0] gray_next_up(input logic [1:0] ab);
      logic [1:0] nxt;
      case (ab)
         AB_00:   nxt = AB_10;
         AB_10:   nxt = AB_11;
         AB_11:   nxt = AB_01;
         default: nxt = AB_00;
      endcase
      return nxt;
   endfunction

   function automatic quad_tr_e classify(input logic [1:0] old_ab, input logic [1:0] new_ab);
      quad_tr_e tr;
      if (old_ab == new_ab)
         tr = TR_NONE;
      else if ((old_ab ^ new_ab) == 2'b11)
         tr = TR_ILL;
      else if (new_ab == gray_next_up(old_ab))
         tr = TR_UP;
      else
         tr = TR_DN;
      return tr;
   endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Two-phase synchroniser plus stability filter: a new AB value is accepted only after it
// has been sampled unchanged, and different from filt_ab, for FILT_LEN consecutive edges.
module quad_sync_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_in,
   input  logic       b_in,
   output logic [1:0] filt_ab,
   output logic       accept,
   output logic [1:0] new_ab
);

   localparam int CNT_W   = $clog2(FILT_LEN + 1);
   // cnt holds (run length - 2) at the edge before acceptance, so the run completes
   // on the edge where the current sample is the FILT_LEN-th identical one.
   localparam int CNT_TGT = (FILT_LEN >= 2) ? FILT_LEN - 2 : 0;

   logic [SYNC_STAGES-1:0] sync_a;
   logic [SYNC_STAGES-1:0] sync_b;
   logic [1:0]             sample;
   logic [1:0]             prev_ab;
   logic [CNT_W-1:0]       cnt;
   logic                   run_done;

   assign sample   = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
   assign run_done = (FILT_LEN == 1) ||
                     ((sample == prev_ab) && (cnt == CNT_W'(CNT_TGT)));
   assign accept   = (sample != filt_ab) && run_done;
   assign new_ab   = sample;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a  <= '0;
         sync_b  <= '0;
         prev_ab <= '0;
         filt_ab <= '0;
         cnt     <= '0;
      end else begin
         sync_a  <= {sync_a[SYNC_STAGES-2:0], a_in};
         sync_b  <= {sync_b[SYNC_STAGES-2:0], b_in};
         prev_ab <= sample;
         if (accept || (sample == filt_ab) || (sample != prev_ab))
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
         if (accept)
            filt_ab <= sample;
      end
   end

endmodule

// File: rtl/quad_step_decoder.sv
// x4 quadrature decoder: filtered AB transitions become a 1-cycle step plus dir level,
// illegal double-phase jumps raise err. Optional err counter under QUAD_ERR_CNT_EN.
module quad_step_decoder
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_in,
   input  logic        b_in,
   input  logic        en,
   output logic        step,
   output logic        dir,
   output logic        err,
`ifdef QUAD_ERR_CNT_EN
   output logic [7:0]  err_cnt,
   input  logic        err_clr,
`endif
   output quad_state_e dbg_state
);

   logic [1:0]  filt_ab;
   logic [1:0]  new_ab;
   logic        accept;
   quad_state_e state;
   quad_tr_e    tr;

   quad_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
   ) u_filter (
      .clk     (clk),
      .rst     (rst),
      .a_in    (a_in),
      .b_in    (b_in),
      .filt_ab (filt_ab),
      .accept  (accept),
      .new_ab  (new_ab)
   );

   assign tr        = classify(filt_ab, new_ab);
   assign dbg_state = state;

   // The first accepted value after reset only establishes the reference position.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
         step  <= 1'b0;
         dir   <= DIR_UP;
         err   <= 1'b0;
      end else begin
         step <= 1'b0;
         err  <= 1'b0;
         if (accept) begin
            case (state)
               ST_INIT: state <= ST_TRACK;
               default: begin
                  case (tr)
                     TR_UP: begin
                        dir  <= DIR_UP;
                        step <= en;
                     end
                     TR_DN: begin
                        dir  <= DIR_DN;
                        step <= en;
                     end
                     TR_ILL:  err <= 1'b1;
                     default: ;
                  endcase
               end
            endcase
         end
      end
   end

`ifdef QUAD_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || err_clr)
         err_cnt <= 8'h00;
      else if (err && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule
